piece_drop: RTL and testbench
=============================

// Module: piece_drop
// PURPOSE
//  Upstream neighbour of the line-clear/redraw stage. Spawns the current piece into the
//  8x4 board, applies left/right moves and gravity/hard drop with collision checks, and
//  locks the piece into the settled board. It then presents the merged 32-bit board,
//  with a one-cycle valid strobe, to the clear stage.
//  Board map: row r (0=top..7=bottom) = board[31-4r -: 4]; nibble bit 3 = column 0 (left).
// PARAMETERS
//  SPAWN_COL      1   spawn column of the 2x2 piece box's left edge (0..2)
//  TICKS_PER_ROW  2   gravity tick pulses per one-row fall attempt (>=1)
// PORTS
//  clka         in   1   clock; all state updates on falling edge of clka
//  restart      in   1   synchronous active-high reset
//  start        in   1   spawn request; honoured only in IDLE
//  curr_piece   in   2   piece id: 0=O{11,11} 1=bar{00,11} 2=L{10,11} 3=J{01,11} (box rows top,bottom)
//  board_in     in   32  settled board; sampled only in SPAWN
//  tick         in   1   gravity pulse
//  move_left    in   1   shift box one column left
//  move_right   in   1   shift box one column right
//  drop         in   1   hard drop
//  board_out    out  32  settled board including the locked piece; feeds the clear stage
//  board_valid  out  1   one-cycle strobe: board_out was just updated
//  active_board out  32  display view = base|piece while FALL/DROP, else board_out
//  busy         out  1   state is SPAWN, FALL, DROP or LOCK
//  game_over    out  1   spawn collided; sticky until restart
// BEHAVIOUR
//  Reset: clka edge with restart=1 -> state IDLE; board_out=0, board_valid=0, game_over=0,
//   busy=0, x=0, y=0, tick counter=0. Restart has priority in every state, including mid-fall.
//  Position: box column x in 0..2, box top row y in 0..6. The piece mask is the 2x2 shape
//   placed at (x,y). Collide = (mask & base)!=0. Out-of-range positions are illegal.
//  FSM:
//   IDLE : start -> SPAWN. board_valid is cleared after 1 cycle.
//   SPAWN: base<=board_in, piece<=curr_piece, x<=SPAWN_COL, y<=0, tick cnt<=0.
//          Collision at spawn -> OVER. Otherwise -> FALL.
//   FALL : at most one action per cycle. Priority: drop > move_left > move_right > gravity.
//          drop       -> DROP.
//          left/right -> x+/-1 only if in range and no collision; otherwise x is unchanged.
//          gravity    -> on tick, cnt+1. When cnt==TICKS_PER_ROW-1 and tick: cnt<=0 and try y+1.
//                        y==6 or collision -> LOCK; otherwise y<=y+1.
//   DROP : each cycle try y+1. Blocked -> LOCK. tick and moves are ignored.
//   LOCK : board_out<=base|mask, board_valid<=1, -> IDLE. Latency is 1 cycle from LOCK entry.
//   OVER : game_over=1, busy=0. start is ignored. Exit only via restart.
//  start in any non-IDLE state is ignored, not queued. board_in changes outside SPAWN are
//  ignored. Moves and drop in IDLE, SPAWN, LOCK and OVER are ignored.
//  busy, game_over and board_valid are decoded or registered from state. No X on outputs after reset.
// TESTING
//  1 TPR=2, board_in=0, start, piece 0, 14 ticks -> y stops at 6; board_out=32'h0000_0066;
//    board_valid high exactly 1 cycle.
//  2 board_in=32'h0000_000F, piece 1, drop -> board_out=32'h0000_006F; ticks during DROP
//    are ignored.
//  3 board_in=0, piece 0, move_left x3, then drop -> x clamps at 0; board_out=32'h0000_00CC.
//  4 board_in=32'h1111_1111, piece 0, move_right -> blocked, x stays 1; drop ->
//    board_out=32'h1111_1177.
//  5 board_in=32'h6600_0000, start, piece 0 -> game_over=1, busy=0, no board_valid;
//    further start ignored until restart.
//  6 restart asserted mid-FALL -> next edge: IDLE, busy=0, board_out=0, board_valid=0.
//    left+right in the same cycle -> left wins.

Source files
------------

// File: rtl/piece_drop.sv
// piece_drop: spawns a 2x2 piece into the 8x4 board, handles moves, gravity and
// hard drop with collision checks, then locks the piece and emits the merged
// board with a one-cycle valid strobe. All state changes on the falling edge of clka.
module piece_drop #(
  parameter int SPAWN_COL     = 1,
  parameter int TICKS_PER_ROW = 2
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  input  logic [1:0]  curr_piece,
  input  logic [31:0] board_in,
  input  logic        tick,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        drop,
  output logic [31:0] board_out,
  output logic        board_valid,
  output logic [31:0] active_board,
  output logic        busy,
  output logic        game_over
);

  localparam int             CW       = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICKS_PER_ROW - 1);
  localparam logic [1:0]     SPAWN_X  = 2'(SPAWN_COL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_DROP,
    S_LOCK,
    S_OVER
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    base_q, base_d;
  logic [1:0]     piece_q, piece_d;
  logic [1:0]     x_q, x_d;
  logic [2:0]     y_q, y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    boardOut_q, boardOut_d;
  logic           valid_q, valid_d;

  logic [3:0]     shapeCur;
  logic [31:0]    maskCur, maskLeft, maskRight, maskDown, maskSpawn;
  logic           canLeft, canRight, canDown, spawnHit;

  // Shape bits are {top row, bottom row}; within a row the high bit is the left column.
  function automatic logic [3:0] shapeOf(input logic [1:0] id);
    case (id)
      2'd0:    return 4'b1111;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // The box is first placed at row 0, column 0 (top nibbles), then shifted down by
  // four bits per row and one bit per column; x<=2 keeps it inside its nibbles.
  function automatic logic [31:0] maskAt(input logic [3:0] shape, input logic [1:0] x,
                                         input logic [2:0] y);
    logic [31:0] home;
    logic [4:0]  sh;
    home = {shape[3:2], 2'b00, shape[1:0], 2'b00, 24'h000000};
    sh   = {y, 2'b00} + {3'b000, x};
    return home >> sh;
  endfunction

  // Candidate piece masks for the current position and each possible single step.
  always_comb begin
    shapeCur  = shapeOf(piece_q);
    maskCur   = maskAt(shapeCur, x_q, y_q);
    maskLeft  = maskAt(shapeCur, x_q - 2'd1, y_q);
    maskRight = maskAt(shapeCur, x_q + 2'd1, y_q);
    maskDown  = maskAt(shapeCur, x_q, y_q + 3'd1);
    maskSpawn = maskAt(shapeOf(curr_piece), SPAWN_X, 3'd0);
    canLeft   = (x_q != 2'd0) && ((maskLeft  & base_q) == 32'h0);
    canRight  = (x_q != 2'd2) && ((maskRight & base_q) == 32'h0);
    canDown   = (y_q != 3'd6) && ((maskDown  & base_q) == 32'h0);
    spawnHit  = (maskSpawn & board_in) != 32'h0;
  end

  // Next-state logic: one action per FALL cycle, drop > left > right > gravity.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    piece_d    = piece_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    boardOut_d = boardOut_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        base_d  = board_in;
        piece_d = curr_piece;
        x_d     = SPAWN_X;
        y_d     = 3'd0;
        cnt_d   = '0;
        state_d = spawnHit ? S_OVER : S_FALL;
      end
      S_FALL: begin
        if (drop) begin
          state_d = S_DROP;
        end else if (move_left) begin
          if (canLeft) x_d = x_q - 2'd1;
        end else if (move_right) begin
          if (canRight) x_d = x_q + 2'd1;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (canDown) y_d = y_q + 3'd1;
            else         state_d = S_LOCK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (canDown) y_d = y_q + 3'd1;
        else         state_d = S_LOCK;
      end
      S_LOCK: begin
        boardOut_d = base_q | maskCur;
        valid_d    = 1'b1;
        state_d    = S_IDLE;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers on the falling edge; restart overrides everything.
  always_ff @(negedge clka) begin
    if (restart) begin
      state_q    <= S_IDLE;
      base_q     <= 32'h0;
      piece_q    <= 2'd0;
      x_q        <= 2'd0;
      y_q        <= 3'd0;
      cnt_q      <= '0;
      boardOut_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      piece_q    <= piece_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      boardOut_q <= boardOut_d;
      valid_q    <= valid_d;
    end
  end

  assign board_out    = boardOut_q;
  assign board_valid  = valid_q;
  assign busy         = (state_q == S_SPAWN) || (state_q == S_FALL) ||
                        (state_q == S_DROP)  || (state_q == S_LOCK);
  assign game_over    = (state_q == S_OVER);
  assign active_board = ((state_q == S_FALL) || (state_q == S_DROP)) ?
                        (base_q | maskCur) : boardOut_q;

endmodule

// File: tb/tb_piece_drop.sv
// Self-checking bench for piece_drop. Expected locked boards are queued when a
// piece is spawned and compared whenever the DUT raises board_valid.
module tb_piece_drop;

  logic        clka;
  logic        restart;
  logic        start;
  logic [1:0]  curr_piece;
  logic [31:0] board_in;
  logic        tick;
  logic        move_left;
  logic        move_right;
  logic        drop;
  logic [31:0] board_out;
  logic        board_valid;
  logic [31:0] active_board;
  logic        busy;
  logic        game_over;

  int checks   = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  piece_drop #(.SPAWN_COL(1), .TICKS_PER_ROW(2)) dut (
    .clka         (clka),
    .restart      (restart),
    .start        (start),
    .curr_piece   (curr_piece),
    .board_in     (board_in),
    .tick         (tick),
    .move_left    (move_left),
    .move_right   (move_right),
    .drop         (drop),
    .board_out    (board_out),
    .board_valid  (board_valid),
    .active_board (active_board),
    .busy         (busy),
    .game_over    (game_over)
  );

  // The DUT acts on the falling edge, so the bench drives and samples around the rising edge.
  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Holds the given controls for exactly one falling edge, then releases them.
  task automatic applyStimulus(input logic st, input logic ml, input logic mr,
                               input logic dr, input logic tk);
    start      = st;
    move_left  = ml;
    move_right = mr;
    drop       = dr;
    tick       = tk;
    @(posedge clka);
    start      = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    drop       = 1'b0;
    tick       = 1'b0;
  endtask

  // Restart for one edge and confirm every output returns to its idle value.
  task automatic doReset(input string tag);
    restart = 1'b1;
    @(posedge clka);
    restart = 1'b0;
    checkOutput({tag, "_busy"},        {31'b0, busy},        32'h0);
    checkOutput({tag, "_game_over"},   {31'b0, game_over},   32'h0);
    checkOutput({tag, "_board_valid"}, {31'b0, board_valid}, 32'h0);
    checkOutput({tag, "_board_out"},   board_out,            32'h0);
    checkOutput({tag, "_active"},      active_board,         32'h0);
  endtask

  // Requests a spawn and leaves the DUT in FALL (or OVER); optionally queues the lock result.
  task automatic spawnPiece(input logic [1:0] pid, input logic [31:0] brd,
                            input logic doPush, input logic [31:0] expBoard);
    curr_piece = pid;
    board_in   = brd;
    if (doPush) expQ.push_back(expBoard);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bounded wait for the valid strobe, then confirm it lasted exactly one cycle.
  task automatic waitValid(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clka);
      if (board_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_valid_seen"}, {31'b0, found}, 32'h1);
    @(posedge clka);
    checkOutput({tag, "_valid_width"}, {31'b0, board_valid}, 32'h0);
    checkOutput({tag, "_idle_busy"},   {31'b0, busy},        32'h0);
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest queued board.
  always @(posedge clka) begin
    if (board_valid) begin
      if (expQ.size() == 0) checkOutput("unexpected_valid", {31'b0, board_valid}, 32'h0);
      else                  checkOutput("board_out", board_out, expQ.pop_front());
    end
  end

  // Main sequence of scenarios.
  initial begin
    logic [1:0]  pidTab [2] = '{2'd2, 2'd3};
    logic [31:0] expTab [2] = '{32'h0000_0046, 32'h0000_0026};
    restart    = 1'b0;
    start      = 1'b0;
    curr_piece = 2'd0;
    board_in   = 32'h0;
    tick       = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    drop       = 1'b0;
    @(posedge clka);
    doReset("reset");

    // Gravity only: O piece falls to the floor after 14 ticks.
    spawnPiece(2'd0, 32'h0, 1'b1, 32'h0000_0066);
    checkOutput("t1_spawn_active", active_board, 32'h6600_0000);
    checkOutput("t1_busy",         {31'b0, busy}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_half_tick", active_board, 32'h6600_0000);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_at_floor", active_board, 32'h0000_0066);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitValid("t1", 6);

    // Hard drop of a bar onto a full bottom row; ticks and board_in changes ignored.
    spawnPiece(2'd1, 32'h0000_000F, 1'b1, 32'h0000_006F);
    board_in = 32'hF000_0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick = 1'b1;
    waitValid("t2", 12);
    tick = 1'b0;

    // Left moves clamp at column 0; a stray start during FALL is ignored.
    spawnPiece(2'd0, 32'h0, 1'b1, 32'h0000_00CC);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_clamped", active_board, 32'hCC00_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_start_ignored", active_board, 32'hCC00_0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitValid("t3", 12);

    // L and J shapes dropped onto an empty board.
    for (int k = 0; k < 2; k++) begin
      spawnPiece(pidTab[k], 32'h0, 1'b1, expTab[k]);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      waitValid("tLJ", 12);
    end

    // Right move blocked by the occupied rightmost column.
    spawnPiece(2'd0, 32'h1111_1111, 1'b1, 32'h1111_1177);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_blocked", active_board, 32'h7711_1111);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitValid("t4", 12);

    // Left beats right in the same cycle, then restart in the middle of a fall.
    spawnPiece(2'd0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_left_wins", active_board, 32'hCC00_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_right", active_board, 32'h6600_0000);
    doReset("t6_restart");

    // Spawn collision ends the game; start is ignored until restart.
    spawnPiece(2'd0, 32'h6600_0000, 1'b0, 32'h0);
    checkOutput("t5_game_over", {31'b0, game_over}, 32'h1);
    checkOutput("t5_busy",      {31'b0, busy},      32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_still_over", {31'b0, game_over}, 32'h1);
    checkOutput("t5_still_idle", {31'b0, busy},      32'h0);
    doReset("t5_restart");

    for (int i = 0; i < 3; i++) @(posedge clka);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
